// File: rtl/rom_pc_sequencer_pkg.sv
// Shared definitions for the ROM CPU program-counter sequencer: opcode map,
// default widths and the sticky fault-bit indices.
package rom_pc_sequencer_pkg;

  localparam int ADDR_W_DEF      = 16;
  localparam int TGT_W_DEF       = 8;
  localparam int STACK_DEPTH_DEF = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_JMP  = 4'h1,
    OP_BLE  = 4'h2,
    OP_BGE  = 4'h3,
    OP_CALL = 4'h4,
    OP_RET  = 4'h5,
    OP_LD   = 4'h6,
    OP_ST   = 4'h7,
    OP_ALU  = 4'h8,
    OP_VGA  = 4'h9
  } opcode_e;

  // Bit positions in the sticky fault vector; any set bit halts the sequencer.
  localparam int FAULT_OVF = 0;
  localparam int FAULT_UNF = 1;
  localparam int FAULT_W   = 2;

endpackage

// File: rtl/rom_pc_sequencer_if.sv
// Decoder-to-sequencer bundle. Optional NOP-delay signals exist only when
// SEQ_NOP_DELAY_EN is defined.
interface rom_pc_sequencer_if
  import rom_pc_sequencer_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TGT_W   = TGT_W_DEF,
  parameter int DEPTH_W = $clog2(STACK_DEPTH_DEF) + 1
);
  logic               iStall;
  logic               iJump;
  logic               iBranchTaken;
  logic               iCall;
  logic               iRet;
  logic [TGT_W-1:0]   iTarget;
`ifdef SEQ_NOP_DELAY_EN
  logic               iNop;
  logic [23:0]        iNopCount;
`endif
  logic [ADDR_W-1:0]  oAddress;
  logic [DEPTH_W-1:0] oStackDepth;
  logic               oOverflow;
  logic               oUnderflow;
  logic               oHalted;

  modport master (
    output iStall, iJump, iBranchTaken, iCall, iRet, iTarget,
`ifdef SEQ_NOP_DELAY_EN
    output iNop, iNopCount,
`endif
    input  oAddress, oStackDepth, oOverflow, oUnderflow, oHalted
  );

  modport slave (
    input  iStall, iJump, iBranchTaken, iCall, iRet, iTarget,
`ifdef SEQ_NOP_DELAY_EN
    input  iNop, iNopCount,
`endif
    output oAddress, oStackDepth, oOverflow, oUnderflow, oHalted
  );
endinterface

// File: rtl/rom_pc_sequencer_call_stack.sv
// Return-address LIFO with a registered top-of-stack. The parent never issues
// push and pop together and never pushes when full or pops when empty.
module rom_pc_sequencer_call_stack #(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 8,
  localparam int PTR_W      = $clog2(STACK_DEPTH),
  localparam int DEPTH_W    = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [ADDR_W-1:0]  din,
  output logic [ADDR_W-1:0]  tos,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);
  logic [ADDR_W-1:0]  mem [STACK_DEPTH];
  logic [DEPTH_W-1:0] sp;
  logic [ADDR_W-1:0]  tos_q;
  logic [PTR_W-1:0]   below_idx;

  // Entry that becomes the new top after a pop (wraps harmlessly when sp==1).
  assign below_idx = sp[PTR_W-1:0] - PTR_W'(2);

  always_ff @(posedge clk) begin
    if (rst)       sp <= '0;
    else if (push) sp <= sp + DEPTH_W'(1);
    else if (pop)  sp <= sp - DEPTH_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[sp[PTR_W-1:0]] <= din;
      tos_q              <= din;
    end else if (pop) begin
      tos_q <= mem[below_idx];
    end
  end

  assign tos   = tos_q;
  assign depth = sp;
  assign full  = (sp == DEPTH_W'(STACK_DEPTH));
  assign empty = (sp == '0);
endmodule

// File: rtl/rom_pc_sequencer.sv
// PC / control-flow sequencer: RET > CALL > JMP/branch > PC+1, with return
// stack, stall freeze and sticky halt. Optional macro: SEQ_NOP_DELAY_EN.
module rom_pc_sequencer
  import rom_pc_sequencer_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int TGT_W       = TGT_W_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  rom_pc_sequencer_if.slave bus
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

  logic [ADDR_W-1:0]  pc, pc_next, pc_inc, tgt, tos;
  logic [FAULT_W-1:0] fault, fault_set;
  logic               push, pop, full, empty, advance;
  logic [DEPTH_W-1:0] depth;
`ifdef SEQ_NOP_DELAY_EN
  logic [23:0]        nop_cnt, nop_cnt_next;
`endif

  assign pc_inc  = pc + ADDR_W'(1);
  assign tgt     = ADDR_W'(bus.iTarget);
  assign advance = !bus.iStall && (fault == '0);

  always_comb begin
    pc_next   = pc;
    push      = 1'b0;
    pop       = 1'b0;
    fault_set = '0;
`ifdef SEQ_NOP_DELAY_EN
    nop_cnt_next = nop_cnt;
    // A running NOP delay masks every strobe; PC moves on the last count.
    if (nop_cnt != 24'd0) begin
      if (!bus.iStall) begin
        nop_cnt_next = nop_cnt - 24'd1;
        if (nop_cnt == 24'd1) pc_next = pc_inc;
      end
    end else
`endif
    if (advance) begin
      if (bus.iRet) begin
        if (empty) fault_set[FAULT_UNF] = 1'b1;
        else begin
          pc_next = tos;
          pop     = 1'b1;
        end
      end else if (bus.iCall) begin
        if (full) fault_set[FAULT_OVF] = 1'b1;
        else begin
          pc_next = tgt;
          push    = 1'b1;
        end
      end else if (bus.iJump || bus.iBranchTaken) begin
        pc_next = tgt;
      end
`ifdef SEQ_NOP_DELAY_EN
      else if (bus.iNop && (bus.iNopCount != 24'd0)) begin
        nop_cnt_next = bus.iNopCount;
      end
`endif
      else begin
        pc_next = pc_inc;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc    <= '0;
      fault <= '0;
`ifdef SEQ_NOP_DELAY_EN
      nop_cnt <= 24'd0;
`endif
    end else begin
      pc    <= pc_next;
      fault <= fault | fault_set;
`ifdef SEQ_NOP_DELAY_EN
      nop_cnt <= nop_cnt_next;
`endif
    end
  end

  rom_pc_sequencer_call_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (Clock),
    .rst   (Reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .tos   (tos),
    .depth (depth),
    .full  (full),
    .empty (empty)
  );

  assign bus.oAddress    = pc;
  assign bus.oStackDepth = depth;
  assign bus.oOverflow   = fault[FAULT_OVF];
  assign bus.oUnderflow  = fault[FAULT_UNF];
  assign bus.oHalted     = |fault;
endmodule

// File: tb/tb_rom_pc_sequencer.sv
// Directed bench for rom_pc_sequencer (default parameters: 16-bit PC,
// 8-bit target, 8-entry stack). Build with SEQ_NOP_DELAY_EN to cover NOP delays.
module tb_rom_pc_sequencer;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;

  rom_pc_sequencer_if bus ();

  rom_pc_sequencer dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_strobes();
    bus.iStall       = 1'b0;
    bus.iJump        = 1'b0;
    bus.iBranchTaken = 1'b0;
    bus.iCall        = 1'b0;
    bus.iRet         = 1'b0;
    bus.iTarget      = 8'd0;
`ifdef SEQ_NOP_DELAY_EN
    bus.iNop         = 1'b0;
    bus.iNopCount    = 24'd0;
`endif
  endtask

  // One cycle with the given strobes, then all strobes drop.
  task automatic cyc(input logic r, input logic c, input logic j, input logic b, input logic [7:0] t);
    bus.iRet = r; bus.iCall = c; bus.iJump = j; bus.iBranchTaken = b; bus.iTarget = t;
    step();
    clear_strobes();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  initial begin
    clear_strobes();
    Reset = 1'b1;
    step();
    step();
    check_eq("rst_addr",  32'(bus.oAddress),    32'd0);
    check_eq("rst_depth", 32'(bus.oStackDepth), 32'd0);
    check_eq("rst_ovf",   32'(bus.oOverflow),   32'd0);
    check_eq("rst_unf",   32'(bus.oUnderflow),  32'd0);
    check_eq("rst_halt",  32'(bus.oHalted),     32'd0);
    Reset = 1'b0;

    for (int i = 1; i <= 5; i++) begin
      step();
      check_eq($sformatf("seq_%0d", i), 32'(bus.oAddress), 32'(i));
    end

    cyc(0, 0, 1, 0, 8'd14);
    cyc(0, 0, 1, 0, 8'd9);
    check_eq("jmp_9", 32'(bus.oAddress), 32'd9);
    cyc(0, 0, 1, 0, 8'd30);
    cyc(0, 0, 0, 1, 8'd27);
    check_eq("br_27", 32'(bus.oAddress), 32'd27);

    // Nested CALL/RET
    cyc(0, 0, 1, 0, 8'd9);
    cyc(0, 1, 0, 0, 8'd25);
    check_eq("call1_addr",  32'(bus.oAddress),    32'd25);
    check_eq("call1_depth", 32'(bus.oStackDepth), 32'd1);
    cyc(0, 0, 1, 0, 8'd30);
    cyc(0, 1, 0, 0, 8'd100);
    check_eq("call2_addr",  32'(bus.oAddress),    32'd100);
    check_eq("call2_depth", 32'(bus.oStackDepth), 32'd2);
    cyc(1, 0, 0, 0, 8'd0);
    check_eq("ret1_addr",  32'(bus.oAddress),    32'd31);
    check_eq("ret1_depth", 32'(bus.oStackDepth), 32'd1);
    cyc(1, 0, 0, 0, 8'd0);
    check_eq("ret2_addr",  32'(bus.oAddress),    32'd10);
    check_eq("ret2_depth", 32'(bus.oStackDepth), 32'd0);

    // Stall holds PC while a jump is presented
    bus.iStall = 1'b1; bus.iJump = 1'b1; bus.iTarget = 8'd50;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("stall_%0d", i), 32'(bus.oAddress), 32'd10);
    end
    bus.iStall = 1'b0;
    step();
    clear_strobes();
    check_eq("stall_release", 32'(bus.oAddress), 32'd50);

    // RET outranks JMP: stack top is 12
    cyc(0, 0, 1, 0, 8'd11);
    cyc(0, 1, 0, 0, 8'd200);
    check_eq("prio_call", 32'(bus.oAddress), 32'd200);
    cyc(1, 0, 1, 0, 8'd77);
    check_eq("prio_ret_jmp", 32'(bus.oAddress),    32'd12);
    check_eq("prio_depth",   32'(bus.oStackDepth), 32'd0);

    // PC wrap and CALL at 0xFFFF pushing 0
    cyc(0, 0, 1, 0, 8'd255);
    for (int i = 0; i < 65280; i++) step();
    check_eq("wrap_top", 32'(bus.oAddress), 32'hFFFF);
    cyc(0, 1, 0, 0, 8'd5);
    check_eq("wrap_call", 32'(bus.oAddress), 32'd5);
    cyc(1, 0, 0, 0, 8'd0);
    check_eq("wrap_ret", 32'(bus.oAddress), 32'd0);
    cyc(0, 0, 1, 0, 8'd255);
    step();
    check_eq("wrap_inc", 32'(bus.oAddress), 32'd256);

    // Overflow: 9 consecutive CALLs into an 8-entry stack
    do_reset();
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 8'(100 + i));
    check_eq("full_addr",  32'(bus.oAddress),    32'd107);
    check_eq("full_depth", 32'(bus.oStackDepth), 32'd8);
    check_eq("full_halt",  32'(bus.oHalted),     32'd0);
    cyc(0, 1, 0, 0, 8'd200);
    check_eq("ovf_addr",  32'(bus.oAddress),    32'd107);
    check_eq("ovf_depth", 32'(bus.oStackDepth), 32'd8);
    check_eq("ovf_flag",  32'(bus.oOverflow),   32'd1);
    check_eq("ovf_halt",  32'(bus.oHalted),     32'd1);
    check_eq("ovf_unf",   32'(bus.oUnderflow),  32'd0);
    cyc(0, 0, 1, 0, 8'd3);
    cyc(1, 0, 0, 0, 8'd0);
    step();
    check_eq("halt_frozen", 32'(bus.oAddress),    32'd107);
    check_eq("halt_depth",  32'(bus.oStackDepth), 32'd8);

    // Underflow right after reset
    do_reset();
    check_eq("unf_pre_halt", 32'(bus.oHalted), 32'd0);
    cyc(1, 0, 0, 0, 8'd0);
    check_eq("unf_addr", 32'(bus.oAddress),   32'd0);
    check_eq("unf_flag", 32'(bus.oUnderflow), 32'd1);
    check_eq("unf_halt", 32'(bus.oHalted),    32'd1);
    check_eq("unf_ovf",  32'(bus.oOverflow),  32'd0);
    step();
    check_eq("unf_frozen", 32'(bus.oAddress), 32'd0);

    // Reset wins over a simultaneous CALL
    do_reset();
    cyc(0, 1, 0, 0, 8'd60);
    check_eq("pre_rst_depth", 32'(bus.oStackDepth), 32'd1);
    Reset = 1'b1;
    cyc(0, 1, 0, 0, 8'd70);
    Reset = 1'b0;
    check_eq("rst_call_addr",  32'(bus.oAddress),    32'd0);
    check_eq("rst_call_depth", 32'(bus.oStackDepth), 32'd0);

`ifdef SEQ_NOP_DELAY_EN
    begin
      int bad;
      bad = 0;
      do_reset();
      bus.iNop = 1'b1; bus.iNopCount = 24'd4000;
      step();
      clear_strobes();
      bus.iJump = 1'b1; bus.iTarget = 8'd99;
      for (int i = 1; i < 4000; i++) begin
        if (bus.oAddress !== 16'd0) bad++;
        step();
      end
      clear_strobes();
      check_eq("nop_hold", 32'(bad), 32'd0);
      check_eq("nop_last", 32'(bus.oAddress), 32'd0);
      step();
      check_eq("nop_done", 32'(bus.oAddress), 32'd1);
      step();
      check_eq("nop_after", 32'(bus.oAddress), 32'd2);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/rom_pc_sequencer.md
Name: rom_pc_sequencer

Overview:
- Program-counter and control-flow sequencer for the 28-bit ROM instruction CPU.
- Drives the ROM address and resolves JMP, CALL/RET and taken-branch targets.
- Owns a hardware return-address stack and honours datapath stalls (e.g. a pending VGA write).
- Sits between the instruction decoder, which supplies decoded strobes, and the ROM address input.

Parameters:
- ADDR_W, 16, PC and ROM address width.
- TGT_W, 8, width of the branch/jump/call target field in the instruction.
- STACK_DEPTH, 8, return-stack entries; power of two, at least 2.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- iStall  in  1  datapath busy; freeze PC and stack.
- iJump  in  1  JMP decoded this cycle.
- iBranchTaken  in  1  BLE/BGE condition true this cycle.
- iCall  in  1  CALL decoded this cycle.
- iRet  in  1  RET decoded this cycle.
- iTarget  in  TGT_W  target address field.
- oAddress  out  ADDR_W  ROM address (the PC).
- oStackDepth  out  $clog2(STACK_DEPTH)+1  current number of stack entries.
- oOverflow  out  1  sticky: CALL issued with the stack full.
- oUnderflow  out  1  sticky: RET issued with the stack empty.
- oHalted  out  1  sequencer frozen by a fault.

Behaviour:
- Reset (synchronous, active-high): oAddress=0, stack pointer=0, oStackDepth=0, oOverflow=0, oUnderflow=0, oHalted=0. Stack RAM contents are don't-care.
- Reset asserted mid-operation overrides all other inputs in the same cycle.
- Each rising Clock edge with Reset=0, iStall=0 and oHalted=0, the next PC is chosen by priority:
  1. iRet: PC <= top of stack; pop.
  2. iCall: push PC+1; PC <= zero-extended iTarget.
  3. iJump or iBranchTaken: PC <= zero-extended iTarget.
  4. Otherwise: PC <= PC+1, modulo 2^ADDR_W (so 0xFFFF wraps to 0).
- Only the highest-priority strobe acts when several are asserted.
- Latency: a redirect is visible on oAddress one cycle after the strobe. There are no delay slots.
- Push value is PC+1 computed in ADDR_W bits; a CALL at 0xFFFF pushes 0.
- iStall=1: PC, stack and depth hold. Strobes during the stall are ignored, and the decoder re-presents them after the stall.
- CALL with depth==STACK_DEPTH: no push, PC holds, oOverflow<=1, oHalted<=1.
- RET with depth==0: PC holds, oUnderflow<=1, oHalted<=1.
- Halted: all strobes ignored and oAddress frozen. Only Reset clears the halt.
- CALL when depth==STACK_DEPTH-1 is legal and leaves the stack full. RET when depth==1 is legal and leaves it empty.
- oStackDepth updates in the same edge as the push or pop.

Optional Feature:
- Macro: SEQ_NOP_DELAY_EN.
- With the macro defined:
  - Adds inputs iNop (1) and iNopCount (24).
  - A NOP with iNopCount=N>0 loads an internal down-counter. The PC holds for N extra cycles, then advances by 1 (N+1 cycles total on that address).
  - iStall freezes the counter.
  - Reset clears the counter.
  - While the counter is nonzero, all strobes are ignored.
- Without the macro: ports absent; NOP is an ordinary single-cycle PC+1.

Decomposition:
- Shared package/include (existing definitions header):
  - opcode constants already used by the decoder;
  - ADDR_W and TGT_W defaults;
  - a fault-code localparam pair (FAULT_OVF, FAULT_UNF).
- Natural sub-module: call_stack.
  - Parameterised LIFO: push/pop/full/empty/depth, registered top-of-stack read.
  - Simultaneous push and pop is never issued by the parent.

Test Plan:
- Sequential fetch: reset, no strobes for 5 cycles -> oAddress 0,1,2,3,4,5.
- Jump and branch:
  - iJump with iTarget=9 at PC=14 -> next oAddress=9.
  - iBranchTaken with iTarget=27 at PC=30 -> next oAddress=27.
- Nested calls:
  - CALL 25 at PC=9 -> oAddress=25, depth=1.
  - CALL 100 at PC=30 -> oAddress=100, depth=2.
  - RET -> oAddress=31, depth=1.
  - RET -> oAddress=10, depth=0.
- Faults:
  - STACK_DEPTH+1 consecutive CALLs -> the last leaves PC unchanged; oOverflow=1, oHalted=1; subsequent strobes ignored.
  - After Reset, a RET -> oUnderflow=1, oHalted=1.
- Stall and priority:
  - iStall=1 for 3 cycles during iJump -> oAddress frozen.
  - iRet and iJump asserted together with stack top=12 -> oAddress=12.
  - Reset asserted during a CALL -> oAddress=0, depth=0.
- SEQ_NOP_DELAY_EN: iNop with iNopCount=4000 at PC=0 -> oAddress stays 0 for 4001 cycles, then becomes 1.
